fixed_div_seq: RTL and testbench

//  Sequential Q16.16 sign-magnitude divider, q = a / b, using Newton-Raphson reciprocal iteration.

---
 rtl/fixed_div_seq_if.sv | 22 ++
 rtl/fixed_div_seq.sv | 97 +++++++++
 tb/tb_fixed_div_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fixed_div_seq_if.sv
// fixed_div_seq_if: operand/result valid-ready bundle for the sequential divider
interface fixed_div_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic         div_by_zero;
  logic         busy;
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero, busy
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero, busy
  );
endinterface

// File: rtl/fixed_div_seq.sv
// fixed_div_seq: sequential Q16.16 sign-magnitude divider using Newton-Raphson reciprocal iteration
module fixed_div_seq #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int ITERS = 5
) (
  input logic            clk,
  input logic            rst_n,
  fixed_div_seq_if.slave s
);
  localparam int M  = N - 1;
  localparam int CW = $clog2(ITERS + 1);
  localparam int KW = $clog2(M);
  localparam logic [N-1:0] TWO = N'(1) << (Q + 1);
  typedef enum logic [2:0] {IDLE, SEED, MUL_BX, MUL_XD, MUL_AX, DONE} state_t;
  state_t        r_state, w_next;
  logic [M-1:0]  r_a, r_b, w_seed;
  logic [N-1:0]  r_x, r_p, r_q, w_op_x, w_op_y, w_sum, w_mul;
  logic [CW-1:0] r_cnt;
  logic [KW-1:0] w_k;
  logic          r_sgn, r_dz, w_zero, w_last;
  function automatic logic [N-1:0] f_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*M-1:0] prod;
    prod = (2*M)'(x[M-1:0]) * (2*M)'(y[M-1:0]);
    return {x[N-1] ^ y[N-1], M'(prod >> Q)};
  endfunction
  function automatic logic [N-1:0] f_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [M-1:0] mx, my;
    mx = x[M-1:0];
    my = y[M-1:0];
    return (x[N-1] == y[N-1]) ? {x[N-1], mx + my} :
           (mx >= my)         ? {x[N-1], mx - my} : {y[N-1], my - mx};
  endfunction
  // leading-one position of the divisor magnitude, used to seed the reciprocal
  always_comb begin
    w_k = '0;
    for (int i = 0; i < M; i++) if (r_b[i]) w_k = KW'(i);
  end
  assign w_seed = (2*Q - 1 - int'(w_k) > M - 1) ? '1 : M'(1) << (2*Q - 1 - int'(w_k));
  assign w_zero = (r_b == '0);
  assign w_last = (r_cnt == CW'(ITERS - 1));
  // the single shared adder and multiplier; operands steered by state
  assign w_sum  = f_add(TWO, {~r_p[N-1], r_p[M-1:0]});
  assign w_op_x = (r_state == MUL_BX) ? {1'b0, r_b} : (r_state == MUL_AX) ? {1'b0, r_a} : r_x;
  assign w_op_y = (r_state == MUL_XD) ? w_sum : r_x;
  assign w_mul  = f_mul(w_op_x, w_op_y);
  assign s.in_ready    = (r_state == IDLE);
  assign s.out_valid   = (r_state == DONE);
  assign s.busy        = (r_state != IDLE);
  assign s.q           = r_q;
  assign s.div_by_zero = r_dz;
  // next-state: zero divisor skips the iterations but still finalises through MUL_AX
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = s.in_valid ? SEED : IDLE;
      SEED:    w_next = w_zero ? MUL_AX : MUL_BX;
      MUL_BX:  w_next = MUL_XD;
      MUL_XD:  w_next = w_last ? MUL_AX : MUL_BX;
      MUL_AX:  w_next = DONE;
      DONE:    w_next = s.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // state, operand capture and registered arithmetic results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_x     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && s.in_valid) begin
        r_a   <= s.a[M-1:0];
        r_b   <= s.b[M-1:0];
        r_sgn <= s.a[N-1] ^ s.b[N-1];
        r_cnt <= '0;
      end
      if (r_state == SEED) r_x <= {1'b0, w_seed};
      if (r_state == MUL_BX) r_p <= w_mul;
      if (r_state == MUL_XD) begin
        r_x   <= w_mul;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == MUL_AX) begin
        r_q  <= w_zero ? {r_sgn, {M{1'b1}}} : {r_sgn & (|w_mul[M-1:0]), w_mul[M-1:0]};
        r_dz <= w_zero;
      end
    end
  end
endmodule

// File: tb/tb_fixed_div_seq.sv
// tb_fixed_div_seq: directed and randomized checks of fixed_div_seq against a real-valued quotient model
module tb_fixed_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          passed = 0;
  int          lat;
  logic [31:0] qv, q0, av, bv;
  logic        dzv;
  fixed_div_seq_if #(.N(32)) d();
  fixed_div_seq #(.N(32), .Q(16), .ITERS(5)) dut (.clk(clk), .rst_n(rst_n), .s(d.slave));
  always #5 clk = ~clk;
  function automatic real sm2r(input logic [31:0] v);
    return (v[31] ? -1.0 : 1.0) * real'(v[30:0]) / 65536.0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic chk_tol(input string tag, input logic [31:0] obs, input real expv, input real tol);
    real diff;
    diff = sm2r(obs) * 65536.0 - expv * 65536.0;
    if (diff < 0.0) diff = -diff;
    total++;
    assert (diff <= tol) passed++;
    else $error("FAIL %s: got %h (%f) expected %f within %0.0f lsb", tag, obs, sm2r(obs), expv, tol);
  endtask
  task automatic start(input logic [31:0] a_in, input logic [31:0] b_in);
    int n = 0;
    while (d.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_start", 32'(d.in_ready), 32'd1);
    d.in_valid = 1'b1;
    d.a = a_in;
    d.b = b_in;
    @(posedge clk);
    @(negedge clk);
    d.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int l);
    l = 0;
    while (d.out_valid !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask
  task automatic do_op(input logic [31:0] a_in, input logic [31:0] b_in, output int l,
                       output logic [31:0] qo, output logic dzo);
    start(a_in, b_in);
    wait_out(l);
    qo  = d.q;
    dzo = d.div_by_zero;
    d.out_ready = 1'b1;
    @(negedge clk);
    d.out_ready = 1'b0;
  endtask
  initial begin
    d.in_valid = 1'b0;
    d.out_ready = 1'b0;
    d.a = '0;
    d.b = '0;
    #1;
    chk("rst_in_ready", 32'(d.in_ready), 32'd1);
    chk("rst_out_valid", 32'(d.out_valid), 32'd0);
    chk("rst_q", d.q, 32'h0);
    chk("rst_dz", 32'(d.div_by_zero), 32'd0);
    chk("rst_busy", 32'(d.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h0006_0000, 32'h0002_0000, lat, qv, dzv);
    chk("6div2_latency", 32'(lat), 32'd12);
    chk_tol("6div2_q", qv, 3.0, 8.0);
    chk("6div2_dz", 32'(dzv), 32'd0);
    do_op(32'h8001_8000, 32'h0000_8000, lat, qv, dzv);
    chk("neg_latency", 32'(lat), 32'd12);
    chk_tol("neg_q", qv, -3.0, 4.0);
    chk("neg_sign", 32'(qv[31]), 32'd1);
    do_op(32'h0001_0000, 32'h4000_0000, lat, qv, dzv);
    chk_tol("seed_k30_q", qv, 1.0 / 16384.0, 2.0);
    do_op(32'h8000_0000, 32'h0001_0000, lat, qv, dzv);
    chk("neg_zero_norm", qv, 32'h0000_0000);
    do_op(32'h8002_0000, 32'h0000_0000, lat, qv, dzv);
    chk("dz_pos0_latency", 32'(lat), 32'd2);
    chk("dz_pos0_flag", 32'(dzv), 32'd1);
    chk("dz_pos0_q", qv, 32'hFFFF_FFFF);
    do_op(32'h8002_0000, 32'h8000_0000, lat, qv, dzv);
    chk("dz_neg0_latency", 32'(lat), 32'd2);
    chk("dz_neg0_flag", 32'(dzv), 32'd1);
    chk("dz_neg0_q", qv, 32'h7FFF_FFFF);
    start(32'h0005_0000, 32'h0004_0000);
    wait_out(lat);
    chk("hold_latency", 32'(lat), 32'd12);
    q0 = d.q;
    chk_tol("hold_q", q0, 1.25, 8.0);
    for (int i = 0; i < 5; i++) begin
      d.in_valid = (i % 2 == 0);
      d.a = $urandom;
      d.b = $urandom;
      @(negedge clk);
      chk("hold_q_stable", d.q, q0);
      chk("hold_in_ready", 32'(d.in_ready), 32'd0);
      chk("hold_out_valid", 32'(d.out_valid), 32'd1);
    end
    d.in_valid = 1'b0;
    d.out_ready = 1'b1;
    @(negedge clk);
    d.out_ready = 1'b0;
    chk("release_in_ready", 32'(d.in_ready), 32'd1);
    chk("release_busy", 32'(d.busy), 32'd0);
    chk("release_out_valid", 32'(d.out_valid), 32'd0);
    start(32'h0007_0000, 32'h0003_0000);
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(d.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(d.in_ready), 32'd1);
    chk("abort_out_valid", 32'(d.out_valid), 32'd0);
    chk("abort_q", d.q, 32'h0);
    chk("abort_dz", 32'(d.div_by_zero), 32'd0);
    chk("abort_busy", 32'(d.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(32'h0001_0000, 32'h0001_0000, lat, qv, dzv);
    chk("one_latency", 32'(lat), 32'd12);
    chk_tol("one_q", qv, 1.0, 4.0);
    for (int i = 0; i < 200; i++) begin
      int unsigned bm, am;
      bm = $urandom_range(32'd1 << 20, 32'd256);
      am = $urandom_range((bm * 2 > 32'd65536) ? 32'd65536 : bm * 2, 32'd0);
      av = {1'($urandom_range(1, 0)), 31'(am)};
      bv = {1'($urandom_range(1, 0)), 31'(bm)};
      do_op(av, bv, lat, qv, dzv);
      chk("rand_latency", 32'(lat), 32'd12);
      chk_tol("rand_q", qv, sm2r(av) / sm2r(bv), 8.0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
